// File: rtl/sys_defs.sv
// Shared definitions for the ALU issue/wakeup slice: widths, ALU opcodes,
// the result packet carried through the pipeline and result buffer, and the ALU itself.
package sys_defs;

   localparam int ROB_TAG_LEN = 5;
   localparam int XLEN        = 32;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLT,
      ALU_SLTU,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA
   } ALU_FUNC;

   typedef struct packed {
      logic                   valid;
      logic [ROB_TAG_LEN-1:0] tag;
      logic [XLEN-1:0]        value;
   } ALU_RESULT_PKT;

   // Shifts only honour the low five bits of operand B.
   function automatic logic [XLEN-1:0] alu_eval(input ALU_FUNC f,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (f)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_SLT:  return XLEN'($signed(a) < $signed(b));
         ALU_SLTU: return XLEN'(a < b);
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_SLL:  return a << sh;
         ALU_SRL:  return a >> sh;
         ALU_SRA:  return $signed(a) >>> sh;
         default:  return '0;
      endcase
   endfunction

endpackage

// File: rtl/result_fifo.sv
// Result buffer between the ALU pipeline and the CDB: circular FIFO of result packets.
// The head entry is presented combinationally; push and pop may coincide at any fill level.
module result_fifo
   import sys_defs::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  ALU_RESULT_PKT push_data,
   input  logic          pop,
   output logic [WIDTH:0] count,
   output ALU_RESULT_PKT head
);

   localparam logic [WIDTH:0] FULL = (WIDTH+1)'(DEPTH);

   ALU_RESULT_PKT    mem [DEPTH];
   logic [WIDTH-1:0] rd_ptr;
   logic [WIDTH-1:0] wr_ptr;

   assign head = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // The issue credit limit is what keeps these from ever firing.
   a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(push && !pop && count == FULL));
   a_no_underflow: assert property (@(posedge clk) disable iff (reset) pop |-> count != '0);

endmodule

// File: rtl/alu_issue_wakeup.sv
// Far end of the RS issue/wakeup interface: credit-based issue, LATENCY-stage ALU,
// result buffer and CDB broadcast of wakeup tag/value back to the reservation station.
module alu_issue_wakeup
   import sys_defs::*;
#(
   parameter int LATENCY   = 2,
   parameter int BUF_DEPTH = 4,
   parameter int BUF_WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   insn_ready,
   input  logic [ROB_TAG_LEN-1:0] dst_tag,
   input  logic                   start,
   input  ALU_FUNC                func_out,
   input  logic [XLEN-1:0]        v1_out,
   input  logic [XLEN-1:0]        v2_out,
   output logic                   issue,
   output logic                   cdb_req,
   input  logic                   cdb_grant,
   output logic                   wakeup,
   output logic [ROB_TAG_LEN-1:0] wakeup_tag,
   output logic [XLEN-1:0]        wakeup_value
);

   localparam logic [BUF_WIDTH+1:0] CREDITS = (BUF_WIDTH+2)'(BUF_DEPTH);

   logic [BUF_WIDTH:0]     in_flight;
   logic [BUF_WIDTH:0]     buf_count;
   logic [ROB_TAG_LEN-1:0] tag_q;
   logic                   tag_pending;
   logic                   pop;
   ALU_RESULT_PKT          exec_pkt;
   ALU_RESULT_PKT          push_pkt;
   ALU_RESULT_PKT          head_pkt;

   // Every op in flight owns a buffer slot, so the buffer can never overflow.
   assign issue   = insn_ready && !reset
                    && (({1'b0, in_flight} + {1'b0, buf_count}) < CREDITS);
   assign cdb_req = buf_count != '0;
   assign pop     = cdb_req && cdb_grant;

   assign exec_pkt = '{valid: start && tag_pending,
                       tag:   tag_q,
                       value: alu_eval(func_out, v1_out, v2_out)};

   if (LATENCY == 1) begin : g_lat1
      assign push_pkt = exec_pkt;
   end else begin : g_pipe
      ALU_RESULT_PKT pipe_q [LATENCY-1];

      always_ff @(posedge clk) begin
         if (reset) begin
            for (int i = 0; i < LATENCY-1; i++) pipe_q[i] <= '0;
         end else begin
            pipe_q[0] <= exec_pkt;
            for (int i = 1; i < LATENCY-1; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end

      assign push_pkt = pipe_q[LATENCY-2];
   end

   result_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (BUF_WIDTH)
   ) u_result_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_pkt.valid),
      .push_data (push_pkt),
      .pop       (pop),
      .count     (buf_count),
      .head      (head_pkt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         in_flight    <= '0;
         tag_q        <= '0;
         tag_pending  <= 1'b0;
         wakeup       <= 1'b0;
         wakeup_tag   <= '0;
         wakeup_value <= '0;
      end else begin
         case ({issue, push_pkt.valid})
            2'b10:   in_flight <= in_flight + 1'b1;
            2'b01:   in_flight <= in_flight - 1'b1;
            default: in_flight <= in_flight;
         endcase
         // A new issue refills tag_q in the same cycle the previous tag is consumed.
         if (issue) begin
            tag_q       <= dst_tag;
            tag_pending <= 1'b1;
         end else if (start) begin
            tag_pending <= 1'b0;
         end
         wakeup <= pop && head_pkt.valid;
         if (pop) begin
            wakeup_tag   <= head_pkt.tag;
            wakeup_value <= head_pkt.value;
         end
      end
   end

   a_start_has_tag: assert property (@(posedge clk) disable iff (reset) start |-> tag_pending);

endmodule

// File: tb/tb_alu_issue_wakeup.sv
// Bench for alu_issue_wakeup: an RS model drives issue/start from an op queue and a
// scoreboard checks every wakeup tag/value against a constant vector table.
module tb_alu_issue_wakeup;
   import sys_defs::*;

   typedef struct { ALU_FUNC f; logic [XLEN-1:0] a; logic [XLEN-1:0] b; logic [XLEN-1:0] r; } vec_t;
   typedef struct { logic [ROB_TAG_LEN-1:0] tag; int vi; } op_t;
   typedef struct { logic [ROB_TAG_LEN-1:0] tag; logic [XLEN-1:0] value; int icyc; bit lat; } exp_t;

   localparam int NV = 13;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   insn_ready = 1'b0;
   logic [ROB_TAG_LEN-1:0] dst_tag = '0;
   logic                   start = 1'b0;
   ALU_FUNC                func_out = ALU_ADD;
   logic [XLEN-1:0]        v1_out = '0;
   logic [XLEN-1:0]        v2_out = '0;
   logic                   issue;
   logic                   cdb_req;
   logic                   cdb_grant = 1'b0;
   logic                   wakeup;
   logic [ROB_TAG_LEN-1:0] wakeup_tag;
   logic [XLEN-1:0]        wakeup_value;

   vec_t tv [NV];
   op_t  ops_q [$];
   exp_t exp_q [$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_issued = 0;
   int n_wake   = 0;
   int grant_mode = 0;   // 0 off, 1 on, 2 toggle
   bit check_lat  = 1'b0;
   bit pend_valid = 1'b0;
   int pend_vi    = 0;

   alu_issue_wakeup dut (
      .clk          (clk),
      .reset        (reset),
      .insn_ready   (insn_ready),
      .dst_tag      (dst_tag),
      .start        (start),
      .func_out     (func_out),
      .v1_out       (v1_out),
      .v2_out       (v2_out),
      .issue        (issue),
      .cdb_req      (cdb_req),
      .cdb_grant    (cdb_grant),
      .wakeup       (wakeup),
      .wakeup_tag   (wakeup_tag),
      .wakeup_value (wakeup_value)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // RS model and scoreboard, evaluated once per cycle at the falling edge.
   always @(negedge clk) begin
      int   occ;
      bit   exp_issue;
      op_t  op;
      exp_t e;
      cyc++;
      if (wakeup) begin
         n_wake++;
         check("wake_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wake_tag", 32'(wakeup_tag), 32'(e.tag));
            check("wake_value", wakeup_value, e.value);
            if (e.lat) check("wake_latency", 32'(cyc - e.icyc), 32'd4);
         end
      end
      occ = n_issued - n_wake;
      start      = pend_valid;
      func_out   = tv[pend_vi].f;
      v1_out     = tv[pend_vi].a;
      v2_out     = tv[pend_vi].b;
      pend_valid = 1'b0;
      if (reset) begin
         exp_q.delete();
         n_issued = 0;
         n_wake   = 0;
      end
      insn_ready = ops_q.size() != 0;
      dst_tag    = insn_ready ? ops_q[0].tag : '0;
      case (grant_mode)
         0:       cdb_grant = 1'b0;
         1:       cdb_grant = 1'b1;
         default: cdb_grant = cyc[0];
      endcase
      #1;
      exp_issue = insn_ready && !reset && (occ < 4);
      check("issue", 32'(issue), 32'(exp_issue));
      if (issue && ops_q.size() != 0) begin
         op = ops_q.pop_front();
         pend_valid = 1'b1;
         pend_vi    = op.vi;
         exp_q.push_back('{tag: op.tag, value: tv[op.vi].r, icyc: cyc, lat: check_lat});
         n_issued++;
      end
   end

   task automatic drain(input string name, input int max);
      int i;
      for (i = 0; i < max; i++) begin
         @(posedge clk);
         if (exp_q.size() == 0 && ops_q.size() == 0) break;
      end
      check(name, 32'(i < max), 32'd1);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int n_req;
      int base;
      int n_consec;
      int n_seen;
      bit got;

      tv[0]  = '{ALU_ADD,  32'd5,          32'd7,          32'd12};
      tv[1]  = '{ALU_SUB,  32'd10,         32'd3,          32'd7};
      tv[2]  = '{ALU_SLL,  32'd1,          32'd33,         32'd2};
      tv[3]  = '{ALU_SLTU, 32'd1,          32'hffff_fff0,  32'd1};
      tv[4]  = '{ALU_AND,  32'h0000_00f0,  32'h0000_003c,  32'h0000_0030};
      tv[5]  = '{ALU_SUB,  32'd0,          32'd1,          32'hffff_ffff};
      tv[6]  = '{ALU_SLT,  32'hffff_fff0,  32'd1,          32'd1};
      tv[7]  = '{ALU_SRA,  32'h8000_0000,  32'd4,          32'hf800_0000};
      tv[8]  = '{ALU_SRL,  32'h8000_0000,  32'd4,          32'h0800_0000};
      tv[9]  = '{ALU_XOR,  32'hff00_ff00,  32'h0ff0_0ff0,  32'hf0f0_f0f0};
      tv[10] = '{ALU_OR,   32'h1234_0000,  32'h0000_5678,  32'h1234_5678};
      tv[11] = '{ALU_ADD,  32'hffff_ffff,  32'd2,          32'd1};
      tv[12] = '{ALU_SLT,  32'd1,          32'hffff_fff0,  32'd0};

      // Reset with a ready instruction waiting, then a single ADD with grant tied high.
      ops_q.push_back('{tag: 5'd3, vi: 0});
      check_lat  = 1'b1;
      grant_mode = 1;
      repeat (3) @(posedge clk);
      #2;
      check("rst_issue", 32'(issue), 32'd0);
      check("rst_wakeup", 32'(wakeup), 32'd0);
      check("rst_cdb_req", 32'(cdb_req), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      #2 check("issue_after_rst", 32'(issue), 32'd1);
      n_req = 0;
      got   = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk);
         #2;
         if (wakeup) got = 1'b1;
         else if (cdb_req) n_req++;
      end
      check("single_wake_seen", 32'(got), 32'd1);
      check("single_req_cycles", 32'(n_req), 32'd1);
      check("single_wake_tag", 32'(wakeup_tag), 32'd3);
      @(posedge clk);
      #2;
      check("single_wake_pulse", 32'(wakeup), 32'd0);
      check("single_tag_hold", 32'(wakeup_tag), 32'd3);
      check("single_value_hold", wakeup_value, 32'd12);
      drain("single_drain", 20);

      // Four back-to-back issues fill the credits; a fifth stays queued.
      check_lat  = 1'b0;
      grant_mode = 0;
      base = n_issued;
      for (int i = 1; i <= 5; i++) ops_q.push_back('{tag: 5'(i), vi: i});
      repeat (10) @(posedge clk);
      #2;
      check("full_cdb_req", 32'(cdb_req), 32'd1);
      check("full_issued", 32'(n_issued - base), 32'd4);
      check("full_held_back", 32'(ops_q.size()), 32'd1);
      grant_mode = 1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk);
         #2;
         if (wakeup) got = 1'b1;
      end
      n_consec = got ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #2;
         if (wakeup) n_consec++;
      end
      check("full_consecutive_wakes", 32'(n_consec), 32'd4);
      drain("full_drain", 40);

      // Full buffer, one pop frees exactly one credit.
      grant_mode = 0;
      base = n_issued;
      for (int i = 6; i <= 11; i++) ops_q.push_back('{tag: 5'(i), vi: i});
      repeat (10) @(posedge clk);
      check("credit_before_pop", 32'(n_issued - base), 32'd4);
      #1 grant_mode = 1;
      @(posedge clk);
      #1 grant_mode = 0;
      repeat (10) @(posedge clk);
      #2;
      check("credit_one_refill", 32'(n_issued - base), 32'd5);
      check("credit_refill_req", 32'(cdb_req), 32'd1);
      grant_mode = 1;
      drain("credit_drain", 60);

      // Toggling grant while the RS keeps issuing.
      grant_mode = 2;
      for (int i = 0; i < 8; i++) ops_q.push_back('{tag: 5'(12 + i), vi: (i * 5) % NV});
      drain("toggle_drain", 120);

      // Every vector of the table, back to back.
      grant_mode = 1;
      for (int i = 0; i < NV; i++) ops_q.push_back('{tag: 5'(i), vi: i});
      drain("table_drain", 120);

      // Reset with two ops in the pipeline and one buffered.
      grant_mode = 0;
      base = n_issued;
      for (int i = 0; i < 3; i++) ops_q.push_back('{tag: 5'(20 + i), vi: 7 + i});
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk);
         if (n_issued - base >= 3) got = 1'b1;
      end
      check("mid_rst_issued", 32'(got), 32'd1);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      grant_mode = 1;
      n_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #2;
         if (wakeup) n_seen++;
      end
      check("mid_rst_no_wake", 32'(n_seen), 32'd0);
      check("mid_rst_cdb_req", 32'(cdb_req), 32'd0);
      check_lat = 1'b1;
      ops_q.push_back('{tag: 5'd23, vi: 10});
      drain("fresh_drain", 30);
      check("fresh_tag", 32'(wakeup_tag), 32'd23);
      check("fresh_value", wakeup_value, 32'h1234_5678);
      check("final_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
